// File: rtl/alu_mc_pkg.sv
// Shared opcodes, FSM state encoding and width helpers for the multi-cycle Execute ALU.
package alu_mc_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_NOR  = 4'b0100;
    localparam logic [3:0] ALU_SLTU = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_MUL  = 4'b1100;
    localparam logic [3:0] ALU_DIVU = 4'b1110;
    localparam logic [3:0] ALU_REMU = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_e;

    typedef enum logic {
        ITER_MUL = 1'b0,
        ITER_DIV = 1'b1
    } iter_op_e;

    // Shift amounts and the iteration counter both need log2(WIDTH) bits.
    function automatic int shamt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Shared one-bit-per-cycle engine: shift-add multiply and restoring divide over
// a common accumulator / shift register / operand register and counter.
module alu_muldiv_iter
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 32
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             step_i,
    input  logic             abort_i,
    input  iter_op_e         op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] prod_o,
    output logic [WIDTH-1:0] quot_o,
    output logic [WIDTH-1:0] rem_o
);

    localparam int            CW   = shamt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] rem_diff;
    logic             rem_ge;

    // The true remainder difference always fits in WIDTH bits, so the carry bit is not needed.
    always_comb begin
        mul_sum  = {1'b0, acc_q} + (sreg_q[0] ? {1'b0, opnd_q} : '0);
        rem_sh   = {acc_q, sreg_q[WIDTH-1]};
        rem_ge   = (rem_sh >= {1'b0, opnd_q});
        rem_diff = rem_sh[WIDTH-1:0] - opnd_q;
    end

    // Outputs are the values the registers take on the step in flight, so the
    // final answer is available on the same edge as the last iteration.
    assign prod_o = {mul_sum[0], sreg_q[WIDTH-1:1]};
    assign quot_o = {sreg_q[WIDTH-2:0], rem_ge};
    assign rem_o  = rem_ge ? rem_diff : rem_sh[WIDTH-1:0];
    assign done_o = step_i && (cnt_q == LAST);

    // NOTE: every signal driven here is given its hold value first, so no path can infer a latch.
    always_comb begin
        acc_d  = acc_q;
        sreg_d = sreg_q;
        opnd_d = opnd_q;
        cnt_d  = cnt_q;
        if (abort_i) begin
            cnt_d = '0;
        end else if (start_i) begin
            acc_d  = '0;
            cnt_d  = '0;
            sreg_d = (op_i == ITER_MUL) ? b_i : a_i;
            opnd_d = (op_i == ITER_MUL) ? a_i : b_i;
        end else if (step_i) begin
            if (op_i == ITER_MUL) begin
                acc_d  = mul_sum[WIDTH:1];
                sreg_d = prod_o;
            end else begin
                acc_d  = rem_o;
                sreg_d = quot_o;
            end
            cnt_d = done_o ? '0 : cnt_q + CW'(1);
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            sreg_q <= '0;
            opnd_q <= '0;
            cnt_q  <= '0;
        end else begin
            acc_q  <= acc_d;
            sreg_q <= sreg_d;
            opnd_q <= opnd_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Execute-stage ALU: single-cycle ops with a registered result, plus optional
// iterative MUL/DIVU/REMU behind a valid/ready handshake.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int ENABLE_MULDIV = 1
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       control,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             div_by_zero,
    output logic             busy
);

    localparam int SHW = shamt_width(WIDTH);

    state_e           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             overflow_q, overflow_d;
    logic             dbz_q, dbz_d;
    logic             rem_sel_q, rem_sel_d;

    logic             accept, start_mul, start_div;
    logic [WIDTH-1:0] sum, diff, sc_result;
    logic             sc_overflow, sc_dbz;
    logic [SHW-1:0]   shamt;

    logic             iter_done;
    logic [WIDTH-1:0] iter_prod, iter_quot, iter_rem;

    assign busy     = (state_q != ST_IDLE);
    assign in_ready = (state_q == ST_IDLE) && !flush;
    assign accept   = in_valid && in_ready;
    assign shamt    = b[SHW-1:0];
    assign sum      = a + b;
    assign diff     = a - b;

    always_comb begin
        sc_result   = '0;
        sc_overflow = 1'b0;
        sc_dbz      = 1'b0;
        start_mul   = 1'b0;
        start_div   = 1'b0;
        case (control)
            ALU_AND:  sc_result = a & b;
            ALU_OR:   sc_result = a | b;
            ALU_XOR:  sc_result = a ^ b;
            ALU_NOR:  sc_result = ~(a | b);
            ALU_ADD: begin
                sc_result   = sum;
                sc_overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                sc_result   = diff;
                sc_overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SLT:  sc_result = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU: sc_result = {{(WIDTH-1){1'b0}}, a < b};
            ALU_SLL:  sc_result = a << shamt;
            ALU_SRL:  sc_result = a >> shamt;
            ALU_SRA:  sc_result = $unsigned($signed(a) >>> shamt);
            ALU_MUL: begin
                if (ENABLE_MULDIV != 0) start_mul = 1'b1;
            end
            ALU_DIVU, ALU_REMU: begin
                if (ENABLE_MULDIV != 0) begin
                    // A zero divisor is resolved immediately instead of iterating.
                    if (b == '0) begin
                        sc_dbz    = 1'b1;
                        sc_result = (control == ALU_REMU) ? a : '1;
                    end else begin
                        start_div = 1'b1;
                    end
                end
            end
            default: sc_result = '0;
        endcase
    end

    if (ENABLE_MULDIV != 0) begin : g_muldiv
        iter_op_e iter_op;
        logic     iter_step;

        assign iter_step = busy && !flush;
        assign iter_op   = busy ? ((state_q == ST_MUL) ? ITER_MUL : ITER_DIV)
                                : (start_mul ? ITER_MUL : ITER_DIV);

        alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
            .clk     (clk),
            .rst     (rst),
            .start_i (accept && (start_mul || start_div)),
            .step_i  (iter_step),
            .abort_i (flush),
            .op_i    (iter_op),
            .a_i     (a),
            .b_i     (b),
            .done_o  (iter_done),
            .prod_o  (iter_prod),
            .quot_o  (iter_quot),
            .rem_o   (iter_rem)
        );
    end else begin : g_no_muldiv
        assign iter_done = 1'b0;
        assign iter_prod = '0;
        assign iter_quot = '0;
        assign iter_rem  = '0;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && start_mul)      state_d = ST_MUL;
                else if (accept && start_div) state_d = ST_DIV;
            end
            ST_MUL, ST_DIV: begin
                if (flush || iter_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Flags hold between results; an accept and an iterative completion can never coincide.
    always_comb begin
        out_valid_d = 1'b0;
        result_d    = result_q;
        zero_d      = zero_q;
        overflow_d  = overflow_q;
        dbz_d       = dbz_q;
        rem_sel_d   = rem_sel_q;
        if (iter_done) begin
            out_valid_d = 1'b1;
            if (state_q == ST_MUL) result_d = iter_prod;
            else if (rem_sel_q)    result_d = iter_rem;
            else                   result_d = iter_quot;
            overflow_d  = 1'b0;
            dbz_d       = 1'b0;
            zero_d      = (result_d == '0);
        end else if (accept && !start_mul && !start_div) begin
            out_valid_d = 1'b1;
            result_d    = sc_result;
            overflow_d  = sc_overflow;
            dbz_d       = sc_dbz;
            zero_d      = (sc_result == '0);
        end
        if (accept) rem_sel_d = (control == ALU_REMU);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            overflow_q  <= 1'b0;
            dbz_q       <= 1'b0;
            rem_sel_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            overflow_q  <= overflow_d;
            dbz_q       <= dbz_d;
            rem_sel_q   <= rem_sel_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign result      = result_q;
    assign zero        = zero_q;
    assign overflow    = overflow_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: vector table plus scoreboard on a 32-bit
// instance, hand sequences for latency/flush/reset, and an 8-bit no-muldiv instance.
module tb_alu_mc;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_NOR  = 4'b0100;
    localparam logic [3:0] OP_SLTU = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_MUL  = 4'b1100;
    localparam logic [3:0] OP_DIVU = 4'b1110;
    localparam logic [3:0] OP_REMU = 4'b1111;

    typedef struct {
        int          tag;
        logic [31:0] res;
        logic        ovf;
        logic        dbz;
    } exp_t;

    typedef struct {
        logic [3:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ovf;
        logic        dbz;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready;
    logic [31:0] a, b, result;
    logic [3:0]  control;
    logic        out_valid, zero, overflow, div_by_zero, busy;

    logic        rst8, flush8, in_valid8, in_ready8;
    logic [7:0]  a8, b8, result8;
    logic [3:0]  control8;
    logic        out_valid8, zero8, overflow8, dbz8, busy8;

    int   n_checks = 0;
    int   n_errors = 0;
    int   valid_count = 0;
    int   tag_n = 0;
    bit   ready8_dropped = 1'b0;
    exp_t sb_q[$];
    vec_t vecs[$];

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(32), .ENABLE_MULDIV(1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .control(control), .out_valid(out_valid), .result(result),
        .zero(zero), .overflow(overflow), .div_by_zero(div_by_zero), .busy(busy)
    );

    alu_mc #(.WIDTH(8), .ENABLE_MULDIV(0)) dut8 (
        .clk(clk), .rst(rst8), .flush(flush8), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .control(control8), .out_valid(out_valid8), .result(result8),
        .zero(zero8), .overflow(overflow8), .div_by_zero(dbz8), .busy(busy8)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
        exp_t   e;
        longint s;
        longint lim;
        lim   = 64'sd2147483647;
        e.tag = 0;
        e.res = '0;
        e.ovf = 1'b0;
        e.dbz = 1'b0;
        case (c)
            OP_ADD: begin
                e.res = x + y;
                s     = longint'($signed(x)) + longint'($signed(y));
                e.ovf = (s > lim) || (s < -lim - 1);
            end
            OP_SUB: begin
                e.res = x - y;
                s     = longint'($signed(x)) - longint'($signed(y));
                e.ovf = (s > lim) || (s < -lim - 1);
            end
            OP_MUL:  e.res = x * y;
            OP_DIVU: if (y == 0) begin e.res = '1; e.dbz = 1'b1; end else e.res = x / y;
            OP_REMU: if (y == 0) begin e.res = x;  e.dbz = 1'b1; end else e.res = x % y;
            default: e.res = '0;
        endcase
        return e;
    endfunction

    // Scoreboard: every out_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst8 && in_ready8 !== 1'b1) ready8_dropped = 1'b1;
        if (out_valid === 1'b1) begin
            valid_count++;
            if (sb_q.size() == 0) begin
                check("spurious_out_valid", out_valid, 1'b0);
            end else begin
                e = sb_q.pop_front();
                check($sformatf("result#%0d", e.tag),   result,      e.res);
                check($sformatf("zero#%0d", e.tag),     zero,        e.res == 32'd0);
                check($sformatf("overflow#%0d", e.tag), overflow,    e.ovf);
                check($sformatf("dbz#%0d", e.tag),      div_by_zero, e.dbz);
            end
        end
    end

    task automatic issue(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                         input exp_t e, input bit track);
        int   waited = 0;
        exp_t t;
        @(negedge clk);
        control  = c;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        #1;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (waited >= 100) check("issue_ready_timeout", in_ready, 1'b1);
        if (track) begin
            t     = e;
            t.tag = tag_n++;
            sb_q.push_back(t);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (sb_q.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("scoreboard_drain", sb_q.size(), 0);
    endtask

    task automatic op8(input logic [3:0] c, input logic [7:0] x, input logic [7:0] y,
                       input logic [7:0] er, input string nm);
        @(negedge clk);
        control8  = c;
        a8        = x;
        b8        = y;
        in_valid8 = 1'b1;
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        check({nm, "_valid"},  out_valid8, 1'b1);
        check({nm, "_result"}, result8,    er);
        check({nm, "_dbz"},    dbz8,       1'b0);
    endtask

    // Abort an in-flight DIVU in cycle 10 via flush or rst, then run ADD 2+3.
    task automatic abort_seq(input bit use_rst);
        exp_t e;
        int   vc0;
        string nm;
        nm  = use_rst ? "rst" : "flush";
        vc0 = valid_count;
        e   = model(OP_DIVU, 32'd100, 32'd7);
        issue(OP_DIVU, 32'd100, 32'd7, e, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        check({nm, "_busy_before"}, busy, 1'b1);
        if (use_rst) rst = 1'b1; else flush = 1'b1;
        @(posedge clk);
        #1;
        if (use_rst) begin
            check("rst_out_valid", out_valid,   1'b0);
            check("rst_result",    result,      32'd0);
            check("rst_zero",      zero,        1'b1);
            check("rst_overflow",  overflow,    1'b0);
            check("rst_dbz",       div_by_zero, 1'b0);
            check("rst_busy",      busy,        1'b0);
        end
        rst   = 1'b0;
        flush = 1'b0;
        #1;
        check({nm, "_in_ready_after"}, in_ready, 1'b1);
        e = model(OP_ADD, 32'd2, 32'd3);
        issue(OP_ADD, 32'd2, 32'd3, e, 1'b1);
        repeat (45) @(negedge clk);
        check({nm, "_pulse_count"}, valid_count - vc0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        int   vk, low, vc0;
        logic [3:0]  rc;
        logic [31:0] ra, rb;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; a = '0; b = '0; control = '0;
        rst8 = 1'b1; flush8 = 1'b0; in_valid8 = 1'b0; a8 = '0; b8 = '0; control8 = '0;

        vecs.push_back('{OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1, 1'b0});
        vecs.push_back('{OP_SUB,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0, 1'b0});
        vecs.push_back('{OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0});
        vecs.push_back('{OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0});
        vecs.push_back('{OP_AND,  32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 1'b0});
        vecs.push_back('{OP_OR,   32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 1'b0});
        vecs.push_back('{OP_XOR,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0, 1'b0});
        vecs.push_back('{OP_NOR,  32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0});
        vecs.push_back('{OP_SLL,  32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1'b0, 1'b0});
        vecs.push_back('{OP_SRL,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0, 1'b0});
        vecs.push_back('{OP_SRA,  32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0, 1'b0});
        vecs.push_back('{OP_SUB,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0});
        vecs.push_back('{OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0});
        vecs.push_back('{4'b1011, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0});
        vecs.push_back('{OP_DIVU, 32'h0000_0009, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1});
        vecs.push_back('{OP_REMU, 32'h0000_0009, 32'h0000_0000, 32'h0000_0009, 1'b0, 1'b1});
        vecs.push_back('{OP_MUL,  32'h0001_0003, 32'h0000_0005, 32'h0005_000F, 1'b0, 1'b0});
        vecs.push_back('{OP_DIVU, 32'd100,       32'd7,         32'd14,        1'b0, 1'b0});
        vecs.push_back('{OP_REMU, 32'd100,       32'd7,         32'd2,         1'b0, 1'b0});
        vecs.push_back('{OP_MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0});
        vecs.push_back('{OP_DIVU, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0});
        vecs.push_back('{OP_REMU, 32'd7,         32'd100,       32'd7,         1'b0, 1'b0});

        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", out_valid,   1'b0);
        check("reset_result",    result,      32'd0);
        check("reset_zero",      zero,        1'b1);
        check("reset_overflow",  overflow,    1'b0);
        check("reset_dbz",       div_by_zero, 1'b0);
        check("reset_busy",      busy,        1'b0);
        @(negedge clk);
        rst  = 1'b0;
        rst8 = 1'b0;
        @(posedge clk);
        #1;
        check("in_ready_after_reset", in_ready, 1'b1);

        foreach (vecs[i]) begin
            e.tag = 0;
            e.res = vecs[i].res;
            e.ovf = vecs[i].ovf;
            e.dbz = vecs[i].dbz;
            issue(vecs[i].c, vecs[i].a, vecs[i].b, e, 1'b1);
        end
        drain();

        // MUL latency: in_ready low for 32 cycles, out_valid in cycle 33; later operand changes ignored.
        @(negedge clk);
        control = OP_MUL; a = 32'h0001_0003; b = 32'h0000_0005; in_valid = 1'b1;
        #1;
        check("mul_accept_ready", in_ready, 1'b1);
        e = model(OP_MUL, 32'h0001_0003, 32'h0000_0005);
        e.tag = tag_n++;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0; a = '1; b = '1; control = OP_ADD;
        vk  = 0;
        low = 0;
        for (int k = 1; k <= 40 && vk == 0; k++) begin
            @(negedge clk);
            if (out_valid) vk = k;
            else if (!in_ready && busy) low++;
        end
        check("mul_latency",          vk,       33);
        check("mul_ready_low_cycles", low,      32);
        check("mul_ready_at_done",    in_ready, 1'b1);
        drain();

        // A flush during the completion cycle of a single-cycle op leaves its out_valid intact.
        vc0 = valid_count;
        e   = model(OP_ADD, 32'd10, 32'd20);
        issue(OP_ADD, 32'd10, 32'd20, e, 1'b1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        drain();
        check("flush_keeps_completion", valid_count - vc0, 1);

        // flush coincident with in_valid accepts nothing.
        vc0 = valid_count;
        @(negedge clk);
        control = OP_ADD; a = 32'd1; b = 32'd1; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; flush = 1'b0;
        repeat (3) @(negedge clk);
        check("flush_blocks_accept", valid_count - vc0, 0);

        abort_seq(1'b0);
        abort_seq(1'b1);

        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 4))
                0:       rc = OP_ADD;
                1:       rc = OP_SUB;
                2:       rc = OP_MUL;
                3:       rc = OP_DIVU;
                default: rc = OP_REMU;
            endcase
            ra = $urandom;
            rb = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            issue(rc, ra, rb, model(rc, ra, rb), 1'b1);
        end
        drain();

        op8(OP_SRA,  8'h80, 8'h03, 8'hF0, "w8_sra");
        op8(OP_MUL,  8'h03, 8'h05, 8'h00, "w8_mul_undef");
        op8(OP_DIVU, 8'h09, 8'h00, 8'h00, "w8_divu_undef");
        op8(OP_SLL,  8'h01, 8'h0A, 8'h04, "w8_sll");
        @(posedge clk);
        #1;
        check("w8_valid_pulse_ends", out_valid8, 1'b0);
        check("w8_in_ready_never_dropped", ready8_dropped, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
